// File: rtl/ldpc_parity_packer.sv
// Serial-to-byte packer for LDPC encoder output: gathers bits MSB first into bytes
// and frames them with start/end flags for a frame of 45*(q-1) bytes.
module ldpc_parity_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg_q,
    input  logic       cfg_load,
    input  logic       src_bits,
    input  logic       src_valid,
    output logic       src_ready,
    output logic [7:0] dst_byte,
    output logic       dst_valid,
    input  logic       dst_ready,
    output logic       dst_start_frame,
    output logic       dst_end_frame,
    output logic       frame_done,
    output logic       cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [12:0] byte_cnt_q, byte_cnt_d;
    logic [12:0] byte_total_q, byte_total_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dst_byte_q, dst_byte_d;
    logic        dst_valid_q, dst_valid_d;
    logic        start_q, start_d;
    logic        end_q, end_d;
    logic        frame_done_q, frame_done_d;
    logic        cfg_err_q, cfg_err_d;

    logic        bit_xfer;
    logic        byte_xfer;
    logic        all_assembled;

    assign all_assembled = (byte_cnt_q == byte_total_q);

    // The 8th bit may only be taken if the output slot is free or emptying this cycle.
    assign src_ready = (state_q == RUN) && !all_assembled &&
                       !((bit_cnt_q == 3'd7) && dst_valid_q && !dst_ready);

    assign bit_xfer  = src_valid && src_ready;
    assign byte_xfer = dst_valid_q && dst_ready;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        byte_total_d = byte_total_q;
        shift_d      = shift_q;
        dst_byte_d   = dst_byte_q;
        dst_valid_d  = dst_valid_q;
        start_d      = start_q;
        end_d        = end_q;
        frame_done_d = 1'b0;
        cfg_err_d    = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    if (cfg_q < 8'd2) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d    = 1'b0;
                        byte_total_d = 13'(cfg_q - 8'd1) * 13'd45;
                        bit_cnt_d    = 3'd0;
                        byte_cnt_d   = 13'd0;
                        shift_d      = 8'h00;
                        state_d      = RUN;
                    end
                end
            end
            RUN: begin
                if (byte_xfer) begin
                    dst_valid_d = 1'b0;
                    if (end_q) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end
                end
                if (bit_xfer) begin
                    shift_d   = {shift_q[6:0], src_bits};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    // A new byte may overwrite the slot on the same edge the old one leaves.
                    if (bit_cnt_q == 3'd7) begin
                        dst_byte_d  = {shift_q[6:0], src_bits};
                        dst_valid_d = 1'b1;
                        start_d     = (byte_cnt_q == 13'd0);
                        end_d       = (byte_cnt_q == byte_total_q - 13'd1);
                        byte_cnt_d  = byte_cnt_q + 13'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 13'd0;
            byte_total_q <= 13'd0;
            shift_q      <= 8'h00;
            dst_byte_q   <= 8'h00;
            dst_valid_q  <= 1'b0;
            start_q      <= 1'b0;
            end_q        <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_total_q <= byte_total_d;
            shift_q      <= shift_d;
            dst_byte_q   <= dst_byte_d;
            dst_valid_q  <= dst_valid_d;
            start_q      <= start_d;
            end_q        <= end_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign dst_byte        = dst_byte_q;
    assign dst_valid       = dst_valid_q;
    assign dst_start_frame = start_q;
    assign dst_end_frame   = end_q;
    assign frame_done      = frame_done_q;
    assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_ldpc_parity_packer.sv
// Randomized bench for ldpc_parity_packer: a bit-queue model predicts every output each
// cycle; directed steps pin the model with hand-computed bytes, counts and flags.
module tb_ldpc_parity_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cfg_q = 8'd0;
    logic       cfg_load = 1'b0;
    logic       src_bits = 1'b0;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic [7:0] dst_byte;
    logic       dst_valid;
    logic       dst_ready = 1'b0;
    logic       dst_start_frame;
    logic       dst_end_frame;
    logic       frame_done;
    logic       cfg_err;

    ldpc_parity_packer dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_q           (cfg_q),
        .cfg_load        (cfg_load),
        .src_bits        (src_bits),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .dst_byte        (dst_byte),
        .dst_valid       (dst_valid),
        .dst_ready       (dst_ready),
        .dst_start_frame (dst_start_frame),
        .dst_end_frame   (dst_end_frame),
        .frame_done      (frame_done),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame is a run of accepted bits; byte k is bits 8k..8k+7.
    bit   m_active = 1'b0;
    bit   m_done   = 1'b0;
    bit   m_err    = 1'b0;
    bit   m_loaded = 1'b0;
    int   m_total  = 0;
    int   m_bits   = 0;
    int   m_out    = 0;
    bit   m_q[$];

    // Observations of the DUT itself, used by the directed steps.
    int   dut_bytes = 0;
    int   last_frame_bytes = 0;
    int   done_cnt = 0;
    int   stall_cnt = 0;

    always @(negedge clk) begin
        logic       exp_valid;
        logic       exp_sr;
        logic [7:0] eb;
        logic       bit_acc;
        logic       byte_xfer;

        exp_valid = ((m_bits / 8) > m_out);
        exp_sr    = m_active && (m_bits < 8 * m_total) &&
                    !(((m_bits % 8) == 7) && exp_valid && !dst_ready);

        check("dst_valid", 32'(dst_valid), 32'(exp_valid));
        check("src_ready", 32'(src_ready), 32'(exp_sr));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        if (exp_valid) begin
            eb = 8'h00;
            for (int i = 0; i < 8; i++) eb = {eb[6:0], m_q[8 * m_out + i]};
            check("dst_byte", 32'(dst_byte), 32'(eb));
            check("dst_start_frame", 32'(dst_start_frame), 32'(m_out == 0));
            check("dst_end_frame", 32'(dst_end_frame), 32'(m_out == m_total - 1));
        end else if (!m_loaded) begin
            check("idle dst_byte", 32'(dst_byte), 0);
            check("idle dst_start_frame", 32'(dst_start_frame), 0);
            check("idle dst_end_frame", 32'(dst_end_frame), 0);
        end

        if (frame_done) begin
            done_cnt++;
            last_frame_bytes = dut_bytes;
            dut_bytes = 0;
        end
        if (dst_valid && dst_ready) dut_bytes++;
        if (dst_valid && !dst_ready && !src_ready) stall_cnt++;

        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_loaded = 1'b0;
            m_total = 0; m_bits = 0; m_out = 0;
            m_q.delete();
            dut_bytes = 0;
        end else begin
            bit_acc   = src_valid && exp_sr;
            byte_xfer = exp_valid && dst_ready;
            if (m_done) begin
                m_done = 1'b0;
            end else if (!m_active && cfg_load) begin
                if (cfg_q < 8'd2) begin
                    m_err = 1'b1;
                end else begin
                    m_err = 1'b0;
                    m_active = 1'b1;
                    m_total = 45 * (int'(cfg_q) - 1);
                    m_bits = 0;
                    m_out = 0;
                    m_q.delete();
                end
            end
            if (bit_acc) begin
                m_q.push_back(src_bits);
                m_bits++;
                if ((m_bits % 8) == 0) m_loaded = 1'b1;
            end
            if (byte_xfer) begin
                if (m_out == m_total - 1) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
                m_out++;
            end
        end
    end

    // Stimulus controls, all owned by the initial block below.
    bit rand_en = 1'b0;
    int vprob = 100;
    int rprob = 100;
    bit hold_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_en) begin
            src_bits  = 1'($urandom_range(1, 0));
            src_valid = ($urandom_range(99) < vprob);
            dst_ready = hold_ready ? 1'b0 : ($urandom_range(99) < rprob);
        end
    endtask

    task automatic run_until_done(input int budget, input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check({name, " frame_done seen"}, 32'(done_cnt != d0), 1);
    endtask

    initial begin
        logic [7:0] pat;
        int n;
        int s0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset src_ready", 32'(src_ready), 0);
        check("reset dst_valid", 32'(dst_valid), 0);
        check("reset dst_byte", 32'(dst_byte), 0);
        check("reset cfg_err", 32'(cfg_err), 0);

        // Illegal q values raise the sticky error and never arm a frame.
        cfg_q = 8'd1; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0; src_valid = 1'b1; src_bits = 1'b1;
        tick();
        check("q=1 cfg_err", 32'(cfg_err), 1);
        check("q=1 src_ready", 32'(src_ready), 0);
        cfg_q = 8'd0; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (3) tick();
        check("q=0 cfg_err", 32'(cfg_err), 1);
        check("q=0 src_ready", 32'(src_ready), 0);

        // q=2 frame starting with 1,0,1,0,1,1,0,1 -> first byte 8'hAD.
        src_valid = 1'b0; dst_ready = 1'b1;
        cfg_q = 8'd2; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("valid load clears cfg_err", 32'(cfg_err), 0);
        check("run src_ready", 32'(src_ready), 1);
        pat = 8'b1010_1101;
        for (int i = 0; i < 8; i++) begin
            src_bits = pat[7 - i];
            src_valid = 1'b1;
            tick();
        end
        check("pattern dst_byte", 32'(dst_byte), 32'h0000_00AD);
        check("pattern dst_valid", 32'(dst_valid), 1);
        check("pattern start flag", 32'(dst_start_frame), 1);
        rand_en = 1'b1; vprob = 100; rprob = 100;
        run_until_done(1000, "q=2");
        check("q=2 byte count", last_frame_bytes, 45);

        // q=3 with random gaps, a stray load mid-frame and a 20-cycle stall.
        vprob = 70; rprob = 60;
        cfg_q = 8'd3; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (100) tick();
        cfg_q = 8'd7; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (40) tick();
        s0 = stall_cnt;
        vprob = 100; hold_ready = 1'b1;
        repeat (20) tick();
        hold_ready = 1'b0; vprob = 70;
        check("stall drops src_ready", 32'(stall_cnt > s0), 1);
        run_until_done(5000, "q=3");
        check("q=3 byte count", last_frame_bytes, 90);

        // q=135 interrupted by reset at byte 20, then a complete frame.
        vprob = 100; rprob = 100;
        cfg_q = 8'd135; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        n = 0;
        while (dut_bytes < 20 && n < 1000) begin
            tick();
            n++;
        end
        check("reach byte 20", 32'(dut_bytes >= 20), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst dst_valid", 32'(dst_valid), 0);
        check("mid rst src_ready", 32'(src_ready), 0);
        check("mid rst dst_byte", 32'(dst_byte), 0);
        check("mid rst start", 32'(dst_start_frame), 0);
        check("mid rst end", 32'(dst_end_frame), 0);
        check("mid rst frame_done", 32'(frame_done), 0);
        check("mid rst cfg_err", 32'(cfg_err), 0);
        cfg_q = 8'd135; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        run_until_done(60000, "q=135");
        check("q=135 byte count", last_frame_bytes, 6030);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
